// File: rtl/ram_snapshot_fetch.sv
// Double-buffered RAM snapshot fetcher feeding the vga register display.
// A back bank is filled word by word from the RAM read port; the front bank
// the vga reads only changes on a frame_start swap, so frames never tear.
module ram_snapshot_fetch #(
    parameter int RAM_WIDTH          = 16,
    parameter int RAM_REGISTER_COUNT = 16,
    parameter int ADDR_WIDTH         = 4
) (
    input  logic                  CLK_50,
    input  logic                  RST,
    input  logic                  frame_start,
    input  logic                  cpu_busy,
    output logic                  re,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [RAM_WIDTH-1:0]  rdata,
    input  logic [ADDR_WIDTH-1:0] disp_index,
    output logic [RAM_WIDTH-1:0]  disp_data,
    output logic                  snapshot_valid,
    output logic                  fetch_active,
    output logic [7:0]            overrun_count
);
    typedef enum logic [1:0] {IDLE, READ, WAIT, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(RAM_REGISTER_COUNT - 1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  bank_sel;
    logic [RAM_WIDTH-1:0]  bank [2][RAM_REGISTER_COUNT];

    // State register; reset aborts any fetch in progress.
    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode: READ waits out cpu_busy, WAIT walks idx to the last word.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = READ;
            READ:    if (!cpu_busy) state_nxt = WAIT;
            WAIT:    state_nxt = (idx == LAST_IDX) ? DONE : READ;
            DONE:    if (frame_start) state_nxt = READ;
            default: state_nxt = IDLE;
        endcase
    end

    // Read port, word index, bank swap and overrun bookkeeping.
    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) begin
            re             <= 1'b0;
            addr           <= '0;
            idx            <= '0;
            bank_sel       <= 1'b0;
            snapshot_valid <= 1'b0;
            overrun_count  <= '0;
        end else begin
            case (state)
                IDLE: if (frame_start) idx <= '0;
                READ: begin
                    re <= !cpu_busy;
                    if (!cpu_busy) addr <= idx;
                end
                WAIT: begin
                    re <= 1'b0;
                    if (idx != LAST_IDX) idx <= idx + 1'b1;
                end
                DONE: if (frame_start) begin
                    // Swap and start the next fetch in the same cycle.
                    bank_sel       <= ~bank_sel;
                    snapshot_valid <= 1'b1;
                    idx            <= '0;
                end
                default: ;
            endcase
            // A frame boundary during a fetch means the previous snapshot is shown twice.
            if (frame_start && (state == READ || state == WAIT) && overrun_count != 8'hFF)
                overrun_count <= overrun_count + 8'd1;
        end
    end

    // Capture the returning word into the back bank; the front bank is read-only here.
    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < RAM_REGISTER_COUNT; i++)
                    bank[b][i] <= '0;
        end else if (state == WAIT) begin
            bank[~bank_sel][idx] <= rdata;
        end
    end

    // Front-bank lookup for the display; blank until a full snapshot exists.
    always_comb begin
        disp_data = '0;
        if (snapshot_valid && (32'(disp_index) < RAM_REGISTER_COUNT))
            disp_data = bank[bank_sel][disp_index];
    end

    assign fetch_active = (state == READ) || (state == WAIT);

endmodule
